// File: rtl/alu_seq_fsm.sv
// ALU instruction sequencer: on a start request it captures an opcode and the
// register selects, then drives one-hot register strobes and ALU controls
// through read / read / evaluate / write-back. All outputs are registered and
// are Moore outputs of the state and the captured fields.
module alu_seq_fsm #(
    parameter int                  NUM_REGS = 6,
    parameter int                  SEL_W    = 6,
    parameter int                  OP_W     = 3,
    parameter logic [NUM_REGS-1:0] RO_MASK  = 6'b100000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [OP_W:0]       op_code,
    input  logic [SEL_W-1:0]    ri,
    input  logic [SEL_W-1:0]    rj,
    input  logic [SEL_W-1:0]    rd,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [NUM_REGS-1:0] reg_read,
    output logic [NUM_REGS-1:0] reg_write,
    output logic [OP_W-1:0]     alu_op,
    output logic                alu_wr_in1,
    output logic                alu_wr_in2,
    output logic                alu_out_en,
    output logic                alu_rd
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        IN1  = 3'd1,
        IN2  = 3'd2,
        EVAL = 3'd3,
        OUT  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t            state_r;
    logic [OP_W:0]     op_r;
    logic [SEL_W-1:0]  ri_r;
    logic [SEL_W-1:0]  rj_r;
    logic [SEL_W-1:0]  rd_r;
    logic              err_r;
    logic              illegal_s;

    // One-hot strobe for a select; an out-of-range select yields no strobe.
    function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_REGS-1:0] v;
        v = {NUM_REGS{1'b0}};
        for (int k = 0; k < NUM_REGS; k++) begin
            if (sel == SEL_W'(k)) begin
                v[k] = 1'b1;
            end
        end
        return v;
    endfunction

    // Read-only lookup that is safe for selects beyond the register file.
    function automatic logic is_ro(input logic [SEL_W-1:0] sel);
        logic r;
        r = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (sel == SEL_W'(k)) begin
                r = RO_MASK[k];
            end
        end
        return r;
    endfunction

    // Legality of the request presented on the inputs; the destination only
    // matters when the result is actually written back.
    always_comb begin
        illegal_s = 1'b0;
        if ((ri >= SEL_W'(NUM_REGS)) || (rj >= SEL_W'(NUM_REGS))) begin
            illegal_s = 1'b1;
        end else if (!op_code[OP_W] && ((rd >= SEL_W'(NUM_REGS)) || is_ro(rd))) begin
            illegal_s = 1'b1;
        end else begin
            illegal_s = 1'b0;
        end
    end

    // Sequencer state, captured fields and registered strobes for the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            op_r       <= {(OP_W+1){1'b0}};
            ri_r       <= {SEL_W{1'b0}};
            rj_r       <= {SEL_W{1'b0}};
            rd_r       <= {SEL_W{1'b0}};
            err_r      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            reg_read   <= {NUM_REGS{1'b0}};
            reg_write  <= {NUM_REGS{1'b0}};
            alu_op     <= {OP_W{1'b0}};
            alu_wr_in1 <= 1'b0;
            alu_wr_in2 <= 1'b0;
            alu_out_en <= 1'b0;
            alu_rd     <= 1'b0;
        end else begin
            // Every strobe is low unless the state entered below asks for it.
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            reg_read   <= {NUM_REGS{1'b0}};
            reg_write  <= {NUM_REGS{1'b0}};
            alu_op     <= {OP_W{1'b0}};
            alu_wr_in1 <= 1'b0;
            alu_wr_in2 <= 1'b0;
            alu_out_en <= 1'b0;
            alu_rd     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r  <= op_code;
                        ri_r  <= ri;
                        rj_r  <= rj;
                        rd_r  <= rd;
                        err_r <= illegal_s;
                        if (illegal_s) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else begin
                            state_r    <= IN1;
                            reg_read   <= onehot(ri);
                            alu_wr_in1 <= 1'b1;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                IN1: begin
                    state_r    <= IN2;
                    reg_read   <= onehot(rj_r);
                    alu_wr_in2 <= 1'b1;
                end
                IN2: begin
                    state_r    <= EVAL;
                    alu_out_en <= 1'b1;
                    alu_op     <= op_r[OP_W-1:0];
                end
                EVAL: begin
                    if (op_r[OP_W]) begin
                        state_r <= DONE;
                        done    <= 1'b1;
                        err     <= err_r;
                    end else begin
                        state_r   <= OUT;
                        alu_rd    <= 1'b1;
                        reg_write <= onehot(rd_r);
                    end
                end
                OUT: begin
                    state_r <= DONE;
                    done    <= 1'b1;
                    err     <= err_r;
                end
                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_fsm.sv
// Scoreboard bench for alu_seq_fsm: the driver's reference model predicts the
// full per-cycle output trace of every accepted instruction; an independent
// monitor collects the observed trace and compares it when done appears.
module tb_alu_seq_fsm;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] op_code;
    logic [5:0] ri, rj, rd;
    logic       busy, done, err;
    logic [5:0] reg_read, reg_write;
    logic [2:0] alu_op;
    logic       alu_wr_in1, alu_wr_in2, alu_out_en, alu_rd;

    alu_seq_fsm dut (
        .clk(clk), .reset(reset), .start(start), .op_code(op_code),
        .ri(ri), .rj(rj), .rd(rd),
        .busy(busy), .done(done), .err(err),
        .reg_read(reg_read), .reg_write(reg_write), .alu_op(alu_op),
        .alu_wr_in1(alu_wr_in1), .alu_wr_in2(alu_wr_in2),
        .alu_out_en(alu_out_en), .alu_rd(alu_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       len;
        logic [4:0][21:0] tr;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   dones = 0;
    int   mbusy = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [21:0] vec(input logic b, input logic d, input logic e,
                                        input logic [5:0] rr, input logic [5:0] rw,
                                        input logic [2:0] op, input logic w1,
                                        input logic w2, input logic oe, input logic ard);
        return {b, d, e, rr, rw, op, w1, w2, oe, ard};
    endfunction

    function automatic logic [21:0] observed();
        return {busy, done, err, reg_read, reg_write, alu_op,
                alu_wr_in1, alu_wr_in2, alu_out_en, alu_rd};
    endfunction

    // Reference model: expected trace from cycle 1 up to and including done.
    function automatic exp_t model(input logic [3:0] op, input logic [5:0] a,
                                   input logic [5:0] b, input logic [5:0] d);
        exp_t       e;
        logic       cmp;
        logic       ok;
        logic [5:0] one;
        e   = '0;
        one = 6'b000001;
        cmp = op[3];
        ok  = (a < 6) && (b < 6) && (cmp || ((d < 6) && (d != 6'd5)));
        if (!ok) begin
            e.len   = 3'd1;
            e.tr[0] = vec(1'b1, 1'b1, 1'b1, 6'd0, 6'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end else begin
            e.tr[0] = vec(1'b1, 1'b0, 1'b0, one << a, 6'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            e.tr[1] = vec(1'b1, 1'b0, 1'b0, one << b, 6'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            e.tr[2] = vec(1'b1, 1'b0, 1'b0, 6'd0, 6'd0, op[2:0], 1'b0, 1'b0, 1'b1, 1'b0);
            if (cmp) begin
                e.len   = 3'd4;
                e.tr[3] = vec(1'b1, 1'b1, 1'b0, 6'd0, 6'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            end else begin
                e.len   = 3'd5;
                e.tr[3] = vec(1'b1, 1'b0, 1'b0, 6'd0, one << d, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
                e.tr[4] = vec(1'b1, 1'b1, 1'b0, 6'd0, 6'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
        return e;
    endfunction

    // One clock: the model sees the same inputs the DUT sampled at this edge.
    task automatic step();
        exp_t e;
        @(posedge clk);
        if (reset) begin
            mbusy = 0;
        end else if (mbusy == 0) begin
            if (start) begin
                e = model(op_code, ri, rj, rd);
                q.push_back(e);
                mbusy = int'(e.len);
            end
        end else begin
            mbusy--;
        end
        #1;
    endtask

    task automatic wait_idle();
        while (mbusy != 0) step();
    endtask

    task automatic issue(input logic [3:0] op, input logic [5:0] a,
                         input logic [5:0] b, input logic [5:0] d);
        wait_idle();
        op_code = op; ri = a; rj = b; rd = d; start = 1'b1;
        step();
        start = 1'b0;
        wait_idle();
    endtask

    // Monitor: collects the trace while busy and scores it when done shows.
    logic [21:0] obuf [0:7];
    int          nbuf = 0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            nbuf = 0;
            chk("outputs_in_reset", {10'd0, observed()}, 32'd0);
        end else if (!busy) begin
            if (nbuf != 0) begin
                chk("busy_fell_without_done", nbuf, 32'd0);
                nbuf = 0;
            end
            chk("idle_outputs", {10'd0, observed()}, 32'd0);
        end else begin
            if (nbuf < 8) obuf[nbuf] = observed();
            nbuf++;
            if (done) begin
                dones++;
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("latency", nbuf, {29'd0, e.len});
                    for (int i = 0; i < int'(e.len) && i < nbuf; i++) begin
                        chk($sformatf("trace_cycle%0d", i + 1), {10'd0, obuf[i]}, {10'd0, e.tr[i]});
                    end
                end
                nbuf = 0;
            end else if (nbuf > 6) begin
                chk("done_timeout", nbuf, 32'd5);
                nbuf = 0;
            end
        end
    end

    initial begin
        int d0;
        reset = 1'b1; start = 1'b0; op_code = 4'd0; ri = 6'd0; rj = 6'd0; rd = 6'd0;
        #1;
        chk("reset_state", {10'd0, observed()}, 32'd0);
        step(); step();
        reset = 1'b0;
        step();

        // Reset in the middle of EVAL: outputs clear immediately, no done.
        op_code = 4'b0010; ri = 6'd1; rj = 6'd2; rd = 6'd3; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        chk("pre_reset_eval", {31'd0, alu_out_en}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_reset_clear", {10'd0, observed()}, 32'd0);
        q.delete();
        mbusy = 0;
        step(); step();
        reset = 1'b0;
        step();

        // Directed cases.
        issue(4'b0010, 6'd1, 6'd2, 6'd3);   // write-back
        issue(4'b1001, 6'd0, 6'd5, 6'd0);   // compare
        issue(4'b0011, 6'd0, 6'd1, 6'd5);   // read-only destination
        issue(4'b0011, 6'd0, 6'd6, 6'd1);   // source out of range
        issue(4'b1100, 6'd2, 6'd3, 6'd63);  // compare ignores rd
        issue(4'b0111, 6'd4, 6'd4, 6'd4);   // same register everywhere

        // start held for 14 cycles: two completions inside the window.
        wait_idle();
        d0 = dones;
        op_code = 4'b0101; ri = 6'd2; rj = 6'd0; rd = 6'd1; start = 1'b1;
        repeat (14) step();
        start = 1'b0;
        chk("held_start_dones", dones - d0, 32'd2);
        wait_idle();

        // Random traffic, start toggling freely including while busy.
        for (int n = 0; n < 600; n++) begin
            start   = ($urandom_range(0, 2) == 0);
            op_code = 4'($urandom);
            ri = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(6, 63)) : 6'($urandom_range(0, 5));
            rj = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(6, 63)) : 6'($urandom_range(0, 5));
            rd = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(6, 63)) : 6'($urandom_range(0, 5));
            step();
        end
        start = 1'b0;
        wait_idle();
        step(); step();
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_fsm.md
# alu_seq_fsm

Parametrised ALU instruction sequencer for the simple CPU datapath. On a `start` pulse it captures an opcode and operand selects, then walks the register file and ALU through a fixed read / read / evaluate / write-back sequence using one-hot register strobes. Compared with the fixed-size ALU control FSM, it adds:

- configurable register count and read-only registers,
- a separate destination register,
- a no-write-back (compare) mode,
- illegal-select error reporting,
- an explicit `busy`/`done` handshake.

## Interface
Parameters:
- NUM_REGS, 6, number of register-file entries addressed by one-hot strobes (index 0..NUM_REGS-1)
- SEL_W, 6, width of register select fields
- OP_W, 3, width of ALU operation code driven to the ALU
- RO_MASK, 6'b100000 (NUM_REGS bits), bit k=1 marks register k as read-only (may be a source, never a destination)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- op_code  in  OP_W+1  [OP_W-1:0] ALU operation; [OP_W] = 1 selects no-write-back (compare) mode
- ri  in  SEL_W  first source select
- rj  in  SEL_W  second source select
- rd  in  SEL_W  destination select
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = instruction rejected
- reg_read  out  NUM_REGS  one-hot register output-enable
- reg_write  out  NUM_REGS  one-hot register load-enable
- alu_op  out  OP_W  operation code to the ALU
- alu_wr_in1  out  1  load ALU operand latch 1
- alu_wr_in2  out  1  load ALU operand latch 2
- alu_out_en  out  1  ALU evaluate/result latch enable
- alu_rd  out  1  ALU result drive onto bus

## Operation
- States: IDLE, IN1, IN2, EVAL, OUT, DONE. Outputs are Moore, decoded from the state and the captured fields.
- IDLE + start=1: capture op_code/ri/rj/rd into internal registers; check legality.
  - Illegal if ri≥NUM_REGS, or rj≥NUM_REGS, or (write-back mode and (rd≥NUM_REGS or RO_MASK[rd]=1)).
  - Legal → IN1. Illegal → DONE with err flag set.
- IN1: reg_read[ri]=1, alu_wr_in1=1 → IN2.
- IN2: reg_read[rj]=1, alu_wr_in2=1 → EVAL.
- EVAL: alu_out_en=1, alu_op=captured op.
  - Write-back mode → OUT.
  - Compare mode → DONE (OUT skipped).
- OUT: alu_rd=1, reg_write[rd]=1 → DONE.
- DONE: done=1, err=captured error flag → IDLE.
- In every state, all strobes not listed for it are 0. alu_op is 0 outside EVAL. At most one reg_read bit and one reg_write bit are ever high.
- ri=rj is legal: the same register is read twice. rd may equal ri or rj.
- start is ignored while busy=1, including in DONE. No request is queued. Inputs are don't-care outside the IDLE capture edge.
- Reset (any cycle, including mid-sequence): state→IDLE, captured fields cleared, all outputs 0 immediately and asynchronously. An interrupted instruction produces no done pulse.

## Timing
- Reset values: busy, done, err, alu_* = 0; reg_read = reg_write = 0.
- Cycle 0 = edge where start is accepted. Per-state strobes are visible in the cycle after entering the state.
- Legal write-back instruction: IN1, IN2, EVAL, OUT, DONE occupy cycles 1–5. done is high in cycle 5. Next start is accepted at the end of cycle 6 at the earliest (IDLE re-entered).
- Legal compare instruction: done in cycle 4.
- Illegal instruction: done=err=1 in cycle 1. No strobes are asserted.
- busy rises in cycle 1 and falls when IDLE is re-entered (the cycle after done).
- Back-to-back throughput: one write-back instruction per 6 cycles.

## Test plan
- Reset mid-EVAL (reset asserted during cycle 3) → all outputs 0 in the same cycle, state IDLE, no done pulse. A start issued after reset completes normally.
- NUM_REGS=6, op=3'b010 write-back, ri=1, rj=2, rd=3 → cycle1 reg_read=000010+wr_in1; cycle2 reg_read=000100+wr_in2; cycle3 alu_out_en, alu_op=010; cycle4 alu_rd, reg_write=001000; cycle5 done=1, err=0.
- Compare mode op_code=4'b1001, ri=0, rj=5 → reg_read[5] in cycle 2, alu_op=001 in cycle 3, done in cycle 4. reg_write and alu_rd stay 0 throughout.
- rd=5 (RO_MASK bit set) in write-back mode → done=err=1 in cycle 1, zero strobes. Repeat with rj=6 → same result.
- ri=rj=rd=4 → reg_read=010000 in both cycles 1 and 2; reg_write=010000 in cycle 4.
- start held high continuously for 14 cycles with legal write-back → exactly two instructions complete (done in cycles 5 and 11). start pulses during busy are not counted.
